// File: rtl/tracker_fsm.sv
// tracker_fsm: line-follower controller. Synchronizes and debounces the three
// IR line sensors, steers the two motors and halts after a bounded lost period.
// Build option: TRACKER_SPIN_TURN_EN -- when defined the inner wheel of a turn
// runs backward (pivot turn); when undefined it stops (arc turn).
//
// state    | code | meaning
// IDLE     | 0    | motors stopped, waiting for start and a debounced value
// STRAIGHT | 1    | both wheels forward
// LEFT     | 2    | left turn, right wheel forward, left wheel inner
// RIGHT    | 3    | right turn, left wheel forward, right wheel inner
// LOST     | 4    | line lost, repeating last motion while the timeout runs
// HALT     | 5    | lost timeout expired, motors stopped until start drops
module tracker_fsm #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int LOST_TIMEOUT    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] sensor,
  output logic [1:0] l_mode,
  output logic [1:0] r_mode,
  output logic [2:0] state,
  output logic       lost
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STRAIGHT = 3'd1,
    S_LEFT     = 3'd2,
    S_RIGHT    = 3'd3,
    S_LOST     = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  localparam logic [1:0] M_STOP = 2'd0;
  localparam logic [1:0] M_FWD  = 2'd1;
`ifdef TRACKER_SPIN_TURN_EN
  localparam logic [1:0] M_INNER = 2'd2;
`else
  localparam logic [1:0] M_INNER = M_STOP;
`endif

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_FULL  = DW'(DEBOUNCE_CYCLES);
  localparam logic [25:0]   LOST_LAST = 26'(LOST_TIMEOUT - 1);

  logic [2:0]    sync1, sync2, prev, db;
  logic [DW-1:0] deb_cnt, deb_nxt;
  logic          db_valid;
  state_t        cur_st, nxt_st, last_mv, nxt_last, dir, mv;
  logic [25:0]   lost_cnt, nxt_lost_cnt;
  logic [1:0]    nxt_l, nxt_r;
  logic          nxt_lost;

  // Two-flop synchronizer on each raw sensor bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
    end
  end

  // Length of the current unchanged run of sync2, saturating at DEBOUNCE_CYCLES.
  always_comb begin
    deb_nxt = deb_cnt;
    if (sync2 != prev) deb_nxt = DW'(1);
    else if (deb_cnt != DEB_FULL) deb_nxt = deb_cnt + DW'(1);
  end

  // Accept sync2 once its run is long enough. Re-accepting the value already in
  // db is harmless and is what marks db as trustworthy after reset (db_valid).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= '0;
      deb_cnt  <= '0;
      db       <= '0;
      db_valid <= 1'b0;
    end else begin
      prev    <= sync2;
      deb_cnt <= deb_nxt;
      if (deb_nxt == DEB_FULL) begin
        db       <= sync2;
        db_valid <= 1'b1;
      end
    end
  end

  // Next state, last-motion memory and lost timer.
  always_comb begin
    nxt_st       = cur_st;
    nxt_last     = last_mv;
    nxt_lost_cnt = lost_cnt;
    case (db)
      3'b010, 3'b111: dir = S_STRAIGHT;
      3'b100, 3'b110: dir = S_LEFT;
      3'b001, 3'b011: dir = S_RIGHT;
      3'b000:         dir = S_LOST;
      default:        dir = (cur_st == S_IDLE) ? S_STRAIGHT : cur_st;
    endcase
    if (!start) begin
      nxt_st = S_IDLE;
    end else begin
      case (cur_st)
        S_IDLE:                        nxt_st = db_valid ? dir : S_IDLE;
        S_STRAIGHT, S_LEFT, S_RIGHT:   nxt_st = dir;
        // Any db that maps to a motion state wins over the timeout.
        S_LOST:   nxt_st = (dir == S_LOST && lost_cnt == LOST_LAST) ? S_HALT : dir;
        S_HALT:   nxt_st = S_HALT;
        default:  nxt_st = S_IDLE;
      endcase
    end
    if (nxt_st inside {S_STRAIGHT, S_LEFT, S_RIGHT}) nxt_last = nxt_st;
    else if (nxt_st == S_LOST && cur_st == S_IDLE)  nxt_last = S_STRAIGHT;
    if (nxt_st == S_LOST) nxt_lost_cnt = (cur_st == S_LOST) ? lost_cnt + 26'd1 : '0;
  end

  // Motor commands for the state being entered; LOST replays the last motion.
  always_comb begin
    nxt_l    = M_STOP;
    nxt_r    = M_STOP;
    mv       = (nxt_st == S_LOST) ? nxt_last : nxt_st;
    nxt_lost = (nxt_st == S_LOST) || (nxt_st == S_HALT);
    case (mv)
      S_STRAIGHT: begin nxt_l = M_FWD;   nxt_r = M_FWD;   end
      S_LEFT:     begin nxt_l = M_INNER; nxt_r = M_FWD;   end
      S_RIGHT:    begin nxt_l = M_FWD;   nxt_r = M_INNER; end
      default:    begin nxt_l = M_STOP;  nxt_r = M_STOP;  end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_st   <= S_IDLE;
      last_mv  <= S_STRAIGHT;
      lost_cnt <= '0;
      l_mode   <= M_STOP;
      r_mode   <= M_STOP;
      lost     <= 1'b0;
    end else begin
      cur_st   <= nxt_st;
      last_mv  <= nxt_last;
      lost_cnt <= nxt_lost_cnt;
      l_mode   <= nxt_l;
      r_mode   <= nxt_r;
      lost     <= nxt_lost;
    end
  end

  assign state = cur_st;

endmodule

// File: tb/tb_tracker_fsm.sv
// Bench for tracker_fsm with DEBOUNCE_CYCLES=4, LOST_TIMEOUT=20.
module tb_tracker_fsm;
  localparam int DEB = 4;
  localparam int TMO = 20;
`ifdef TRACKER_SPIN_TURN_EN
  localparam logic [1:0] INNER = 2'd2;
`else
  localparam logic [1:0] INNER = 2'd0;
`endif

  logic       clk, rst, start;
  logic [2:0] sensor;
  logic [1:0] l_mode, r_mode;
  logic [2:0] state;
  logic       lost;
  logic [7:0] outs;
  int total, bad;

  tracker_fsm #(.DEBOUNCE_CYCLES(DEB), .LOST_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .sensor(sensor),
    .l_mode(l_mode), .r_mode(r_mode), .state(state), .lost(lost)
  );

  assign outs = {state, l_mode, r_mode, lost};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: db accepts a value once the last DEB synchronized samples
  // (raw delayed two cycles) all agree; the steering rules work on plain ints.
  int m_st, m_last, m_age, m_db;
  bit m_valid;
  int rq[$];

  function automatic int target_of(int d, int cur);
    case (d)
      2, 7:    return 1;
      4, 6:    return 2;
      1, 3:    return 3;
      0:       return 4;
      default: return (cur == 0) ? 1 : cur;
    endcase
  endfunction

  function automatic logic [7:0] expect_of(int st, int last);
    int eff;
    logic [1:0] l, r;
    eff = (st == 4) ? last : st;
    l = 2'd0;
    r = 2'd0;
    if (eff == 1) begin l = 2'd1; r = 2'd1; end
    else if (eff == 2) begin l = INNER; r = 2'd1; end
    else if (eff == 3) begin l = 2'd1; r = INNER; end
    return {3'(st), l, r, (st == 4 || st == 5)};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st = 0; m_last = 1; m_age = 0; m_db = 0; m_valid = 0;
      rq.delete(); rq.push_back(0); rq.push_back(0);
    end else begin
      int ns, tgt;
      bit same;
      tgt = target_of(m_db, m_st);
      if (!start)                                      ns = 0;
      else if (m_st == 5)                              ns = 5;
      else if (m_st == 0 && !m_valid)                  ns = 0;
      else if (m_st == 4 && tgt == 4 && m_age == TMO-1) ns = 5;
      else                                             ns = tgt;
      if (ns == 4) m_age = (m_st == 4) ? m_age + 1 : 0;
      if (ns == 4 && m_st == 0) m_last = 1;
      else if (ns >= 1 && ns <= 3) m_last = ns;
      m_st = ns;
      if (rq.size() >= DEB + 1) begin
        same = 1;
        for (int i = 1; i < DEB; i++)
          if (rq[rq.size()-2-i] != rq[rq.size()-2]) same = 0;
        if (same) begin m_db = rq[rq.size()-2]; m_valid = 1; end
      end
      rq.push_back(int'(sensor));
      if (rq.size() > DEB + 4) void'(rq.pop_front());
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (state != tgt && n < budget);
    total++;
    if (state != tgt) begin
      bad++;
      $display("FAIL %s: state=%0d want=%0d after %0d cycles", nm, state, tgt, n);
    end
  endtask

  task automatic count_lost(input logic [1:0] exp_r, output int n, output bit ok);
    n = 0;
    ok = 1'b1;
    while (state == 3'd4 && n < 60) begin
      if (lost !== 1'b1 || l_mode !== 2'd1 || r_mode !== exp_r) ok = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rstep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rand", outs, expect_of(m_st, m_last));
    end
  endtask

  typedef struct {
    bit         st;
    logic [2:0] sen;
    int         hold;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok;
    total = 0; bad = 0;
    rst = 1'b0; start = 1'b0; sensor = 3'b000;

    vt[0]  = '{1'b1, 3'b010, 8, {3'd1, 2'd1,  2'd1,  1'b0}};
    vt[1]  = '{1'b1, 3'b110, 8, {3'd2, INNER, 2'd1,  1'b0}};
    vt[2]  = '{1'b1, 3'b011, 8, {3'd3, 2'd1,  INNER, 1'b0}};
    vt[3]  = '{1'b1, 3'b111, 8, {3'd1, 2'd1,  2'd1,  1'b0}};
    vt[4]  = '{1'b1, 3'b100, 8, {3'd2, INNER, 2'd1,  1'b0}};
    vt[5]  = '{1'b1, 3'b101, 8, {3'd2, INNER, 2'd1,  1'b0}};
    vt[6]  = '{1'b1, 3'b001, 8, {3'd3, 2'd1,  INNER, 1'b0}};
    vt[7]  = '{1'b1, 3'b000, 8, {3'd4, 2'd1,  INNER, 1'b1}};
    vt[8]  = '{1'b1, 3'b010, 8, {3'd1, 2'd1,  2'd1,  1'b0}};
    vt[9]  = '{1'b0, 3'b010, 1, {3'd0, 2'd0,  2'd0,  1'b0}};
    vt[10] = '{1'b1, 3'b010, 1, {3'd1, 2'd1,  2'd1,  1'b0}};
    vt[11] = '{1'b0, 3'b000, 8, {3'd0, 2'd0,  2'd0,  1'b0}};
    vt[12] = '{1'b1, 3'b000, 2, {3'd4, 2'd1,  2'd1,  1'b1}};
    vt[13] = '{1'b1, 3'b100, 8, {3'd2, INNER, 2'd1,  1'b0}};
    vt[14] = '{1'b1, 3'b000, 8, {3'd4, INNER, 2'd1,  1'b1}};
    vt[15] = '{1'b0, 3'b000, 1, {3'd0, 2'd0,  2'd0,  1'b0}};

    step(3);
    chk("reset_vals", outs, 8'h00);

    // End-to-end latency: db lands after 2+4 edges, outputs one edge later.
    rst = 1'b1; start = 1'b1; sensor = 3'b010;
    step(6);
    chk("lat_before", outs, 8'h00);
    step(1);
    chk("lat_after", outs, {3'd1, 2'd1, 2'd1, 1'b0});

    start = 1'b0; sensor = 3'b000;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      start = vt[i].st;
      sensor = vt[i].sen;
      step(vt[i].hold);
      chk($sformatf("vec%0d", i), outs, vt[i].exp);
    end

    // Short glitch before a turn must not shift the turn timing.
    start = 1'b1; sensor = 3'b010; step(8);
    chk("gl_straight", outs, {3'd1, 2'd1, 2'd1, 1'b0});
    sensor = 3'b100; step(2);
    sensor = 3'b110; step(6);
    chk("gl_hold", {5'd0, state}, 8'd1);
    step(1);
    chk("gl_left", outs, {3'd2, INNER, 2'd1, 1'b0});

    // A 3-cycle line dropout is shorter than the debounce window.
    sensor = 3'b010; step(8);
    sensor = 3'b000; step(3);
    sensor = 3'b010;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("dropout_nolost", {7'd0, lost}, 8'd0);
    end

    // start low mid-turn.
    sensor = 3'b100; step(8);
    chk("left_pre", outs, {3'd2, INNER, 2'd1, 1'b0});
    start = 1'b0; step(1);
    chk("left_abort", outs, 8'h00);
    start = 1'b1; step(1);
    chk("left_resume", {5'd0, state}, 8'd2);

    // Full lost timeout from RIGHT, then HALT until start drops.
    sensor = 3'b001; step(8);
    chk("right_pre", {5'd0, state}, 8'd3);
    sensor = 3'b000;
    wait_state(3'd4, 12, "enter_lost");
    count_lost(INNER, n, ok);
    chk("lost_len", 8'(n), 8'(TMO));
    chk("lost_modes", {7'd0, ok}, 8'd1);
    chk("halt", outs, {3'd5, 2'd0, 2'd0, 1'b1});
    sensor = 3'b010; step(8);
    chk("halt_sticky", outs, {3'd5, 2'd0, 2'd0, 1'b1});
    start = 1'b0; step(1);
    chk("halt_exit", outs, 8'h00);

    // Reacquisition landing in db on the timeout cycle beats HALT.
    start = 1'b1; sensor = 3'b001; step(8);
    chk("tmo_right", {5'd0, state}, 8'd3);
    sensor = 3'b000;
    wait_state(3'd4, 12, "tmo_lost");
    step(13);
    sensor = 3'b001;
    step(6);
    chk("tmo_still_lost", {5'd0, state}, 8'd4);
    step(1);
    chk("tmo_reacq", outs, {3'd3, 2'd1, INNER, 1'b0});

    // One cycle later is too late.
    sensor = 3'b000;
    wait_state(3'd4, 12, "late_lost");
    step(14);
    sensor = 3'b001;
    step(6);
    chk("tmo_late_halt", outs, {3'd5, 2'd0, 2'd0, 1'b1});
    start = 1'b0; step(1);

    // Asynchronous reset in the middle of a lost count, then a full recount.
    start = 1'b1; sensor = 3'b010; step(8);
    sensor = 3'b000;
    wait_state(3'd4, 12, "rst_lost");
    step(10);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("async_rst", outs, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    wait_state(3'd4, 12, "rst_relost");
    count_lost(2'd1, n, ok);
    chk("relost_len", 8'(n), 8'(TMO));
    chk("relost_modes", {7'd0, ok}, 8'd1);
    chk("relost_halt", {5'd0, state}, 8'd5);

    // Randomized run against the reference model.
    start = 1'b0; sensor = 3'b000;
    do_reset();
    for (int s = 0; s < 300; s++) begin
      int hold;
      start = ($urandom_range(0, 99) < 6) ? 1'b0 : 1'b1;
      sensor = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12);
      if (sensor == 3'b000 && $urandom_range(0, 2) == 0) hold = $urandom_range(15, 30);
      rstep(hold);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tracker_fsm.md
TRACKER_FSM -- requirements
Module: tracker_fsm

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 100000, consecutive stable clk cycles required before a synchronized sensor value is accepted (1 ms at 100 MHz).
REQ-002 Parameter LOST_TIMEOUT, default 50000000, maximum clk cycles spent in LOST before entering HALT (0.5 s).
REQ-003 clk  input  1  system clock, 100 MHz, rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  run enable, level-sensitive, synchronous to clk.
REQ-006 sensor  input  3  raw IR line sensors {left, mid, right}, 1 = on line, asynchronous to clk.
REQ-007 l_mode  output  2  left motor command to the downstream motor block: 0 stop, 1 forward, 2 backward; 3 never driven.
REQ-008 r_mode  output  2  right motor command, same encoding as l_mode.
REQ-009 state  output  3  current FSM state code.
REQ-010 lost  output  1  high while state is LOST or HALT.

Function
REQ-011 sensor SHALL pass through a 2-flop synchronizer per bit before any use.
REQ-012 Debounced value db[2:0] SHALL update to the synchronized value only after it has differed from db and stayed identical for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
REQ-013 State codes: IDLE=0, STRAIGHT=1, LEFT=2, RIGHT=3, LOST=4, HALT=5; codes 6-7 SHALL return to IDLE on the next cycle.
REQ-014 start=0 in any state SHALL force IDLE on the next cycle; IDLE outputs l_mode=r_mode=0.
REQ-015 From IDLE, STRAIGHT, LEFT, RIGHT, LOST with start=1, the next state SHALL follow db: 010 or 111 -> STRAIGHT; 100 or 110 -> LEFT; 001 or 011 -> RIGHT; 000 -> LOST; 101 -> hold current state (from IDLE, 101 -> STRAIGHT).
REQ-016 STRAIGHT SHALL drive l_mode=1, r_mode=1.
REQ-017 LEFT SHALL drive r_mode=1 and inner wheel l_mode per REQ-026; RIGHT mirrors it (l_mode=1, inner r_mode).
REQ-018 LOST SHALL drive the outputs of the last non-LOST motion state (LEFT, RIGHT, or STRAIGHT); from IDLE with db=000, LOST drives STRAIGHT outputs.
REQ-019 A 26-bit lost counter SHALL clear on LOST entry, increment each LOST cycle, and on reaching LOST_TIMEOUT-1 move to HALT on the next cycle.
REQ-020 Reacquisition (db not 000) in the same cycle the timeout is reached SHALL take priority over HALT.
REQ-021 HALT SHALL drive l_mode=r_mode=0 and exit only via start=0 (to IDLE).
REQ-022 state, l_mode, r_mode, lost SHALL be registered; outputs change exactly one clk after the db change that caused the transition.
REQ-023 End-to-end latency from a clean raw sensor step to output change SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles (+/-1 for edge sampling).

Reset
REQ-024 rst=0 SHALL immediately clear synchronizer flops, db to 000, debounce and lost counters to 0, state to IDLE, l_mode=r_mode=0, lost=0, and last-motion memory to STRAIGHT.
REQ-025 Reset asserted mid-turn or mid-LOST SHALL abort without completing the timeout; after release the block SHALL wait in IDLE for start and a debounced sensor value.

Configuration
REQ-026 Macro TRACKER_SPIN_TURN_EN: defined -> inner wheel in LEFT/RIGHT (and LOST repeating them) drives 2 (backward, pivot turn); undefined -> inner wheel drives 0 (stop, arc turn).

Verification (DEBOUNCE_CYCLES=4, LOST_TIMEOUT=20)
REQ-027 rst low, then high, start=1, sensor=010 held -> state 0 until db updates, then state=1, l_mode=1, r_mode=1 after 2+4+1 cycles.
REQ-028 sensor 010 then 110, plus a 2-cycle glitch 100 -> glitch ignored; state=2, r_mode=1, l_mode=0 (2 with TRACKER_SPIN_TURN_EN).
REQ-029 In RIGHT, sensor=000 held -> state=4, lost=1, l_mode=1 for 20 cycles, then state=5, modes 0; start=0 -> state=0, lost=0.
REQ-030 In LOST, sensor=001 arriving at db exactly on timeout cycle -> state=3, no HALT.
REQ-031 sensor=101 while in LEFT -> state stays 2; start=0 mid-LEFT -> next cycle state=0, modes 0.
REQ-032 rst pulsed low during LOST count 10 -> outputs 0 asynchronously; after release with sensor=000, start=1 -> LOST counts a full 20 again.
